// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 extension: register numbers, exception codes
// and SR/Cause field positions.
package cp0_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned EXC_W  = 5;
    localparam int unsigned IP_W   = 8;

    // MFC0/MTC0 register numbers
    typedef enum logic [ADDR_W-1:0] {
        REG_BADVADDR = 5'd8,
        REG_COUNT    = 5'd9,
        REG_COMPARE  = 5'd11,
        REG_SR       = 5'd12,
        REG_CAUSE    = 5'd13,
        REG_EPC      = 5'd14,
        REG_PRID     = 5'd15
    } cp0_reg_e;

    // Exception codes recorded in Cause.ExcCode
    localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    // SR field positions
    localparam int unsigned SR_IE    = 0;
    localparam int unsigned SR_EXL   = 1;
    localparam int unsigned SR_IM_LO = 8;

    // Cause field positions
    localparam int unsigned CAUSE_EXC_LO = 2;
    localparam int unsigned CAUSE_IP_LO  = 8;
    localparam int unsigned CAUSE_TI     = 30;
    localparam int unsigned CAUSE_BD     = 31;

    // Address-error codes are the only ones that capture BadVAddr
    function automatic logic is_addr_exc(input logic [EXC_W-1:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer. Count free-runs (MTC0 load overrides the increment);
// TI sets when the next Count equals Compare and clears on any Compare write.
// Ports: clk, reset (async active-low), wr_count/wr_compare strobes,
//        wr_data, ti, count, compare.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_count,
    input  logic              wr_compare,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ti,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] compare
);

    logic [DATA_W-1:0] count_next_c;

    // Next Count: MTC0 load replaces the increment; wraps naturally
    always_comb begin
        count_next_c = count + DATA_W'(1);
        if (wr_count) begin
            count_next_c = wr_data;
        end
    end

    // Timer state; a Compare write clears TI even if the match would set it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            count <= count_next_c;
            if (wr_compare) begin
                compare <= wr_data;
                ti      <= 1'b0;
            end else if (count_next_c == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_ext.sv
// System-control coprocessor beside the M stage: holds SR, Cause, EPC,
// BadVAddr, PRID and the Count/Compare timer, and decides exception or
// interrupt entry.
// Ports: clk, reset (async active-low); MFC0 rd_addr/rd_data; MTC0
//        wr_en/wr_addr/wr_data; M-stage pc_m, bd_m, exc_code_m, bad_vaddr_m,
//        eret_m; hw_int levels; int_req, epc (combinational) and timer_irq.
module cp0_ext
    import cp0_pkg::*;
#(
    parameter int unsigned       N_HWINT  = 6,
    parameter logic [DATA_W-1:0] PRID_VAL = 32'h1837_3580,
    parameter bit                TIMER_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [DATA_W-1:0]  pc_m,
    input  logic               bd_m,
    input  logic [EXC_W-1:0]   exc_code_m,
    input  logic [DATA_W-1:0]  bad_vaddr_m,
    input  logic               eret_m,
    input  logic [N_HWINT-1:0] hw_int,
    output logic               int_req,
    output logic [DATA_W-1:0]  epc,
    output logic               timer_irq
);

    logic [IP_W-1:0]    sr_im;
    logic               sr_exl;
    logic               sr_ie;
    logic               cause_bd;
    logic [EXC_W-1:0]   cause_exc;
    logic [1:0]         ip_sw;
    logic [N_HWINT-1:0] hw_q;
    logic [DATA_W-3:0]  epc_hi;
    logic [DATA_W-1:0]  badva_q;

    logic               ti;
    logic [DATA_W-1:0]  count;
    logic [DATA_W-1:0]  compare;

    logic [IP_W-1:0]    ip_c;
    logic               irq_pend_c;
    logic [EXC_W-1:0]   exc_rec_c;
    logic               mtc0_c;
    logic [DATA_W-3:0]  epc_entry_c;
    logic               unused_pc_lsb;

    assign unused_pc_lsb = ^pc_m[1:0];

    // IP view: software bits, registered hw lines, TI folded into IP[7]
    always_comb begin
        ip_c       = '0;
        ip_c[1:0]  = ip_sw;
        for (int i = 0; i < int'(N_HWINT); i++) begin
            ip_c[2+i] = hw_q[i];
        end
        ip_c[IP_W-1] = ip_c[IP_W-1] | ti;
    end

    assign irq_pend_c = (|(ip_c & sr_im)) & sr_ie & ~sr_exl;
    assign int_req    = irq_pend_c | (|exc_code_m);
    assign exc_rec_c  = irq_pend_c ? EXC_INT : exc_code_m;
    // Entry drops any MTC0 issued in the same cycle
    assign mtc0_c     = wr_en & ~int_req;
    // Word-aligned PC, backed up one word for a delay-slot instruction
    assign epc_entry_c = pc_m[DATA_W-1:2] - (DATA_W-2)'(bd_m);
    assign epc        = {epc_hi, 2'b00};
    assign timer_irq  = ti;

    // MFC0 read mux; unmapped numbers read 0
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            REG_BADVADDR: rd_data = badva_q;
            REG_COUNT:    rd_data = count;
            REG_COMPARE:  rd_data = compare;
            REG_SR: begin
                rd_data[SR_IM_LO +: IP_W] = sr_im;
                rd_data[SR_EXL]           = sr_exl;
                rd_data[SR_IE]            = sr_ie;
            end
            REG_CAUSE: begin
                rd_data[CAUSE_BD]               = cause_bd;
                rd_data[CAUSE_TI]               = ti;
                rd_data[CAUSE_IP_LO +: IP_W]    = ip_c;
                rd_data[CAUSE_EXC_LO +: EXC_W]  = cause_exc;
            end
            REG_EPC:      rd_data = epc;
            REG_PRID:     rd_data = PRID_VAL;
            default:      rd_data = '0;
        endcase
    end

    // SR/Cause/EPC/BadVAddr; entry beats ERET and MTC0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_exc <= '0;
            ip_sw     <= '0;
            hw_q      <= '0;
            epc_hi    <= '0;
            badva_q   <= '0;
        end else begin
            hw_q <= hw_int;
            if (int_req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd_m;
                cause_exc <= exc_rec_c;
                epc_hi    <= epc_entry_c;
                if (is_addr_exc(exc_rec_c)) begin
                    badva_q <= bad_vaddr_m;
                end
            end else begin
                if (wr_en) begin
                    case (wr_addr)
                        REG_SR: begin
                            sr_im  <= wr_data[SR_IM_LO +: IP_W];
                            sr_exl <= wr_data[SR_EXL];
                            sr_ie  <= wr_data[SR_IE];
                        end
                        REG_CAUSE: ip_sw  <= wr_data[CAUSE_IP_LO +: 2];
                        REG_EPC:   epc_hi <= wr_data[DATA_W-1:2];
                        default: ;
                    endcase
                end
                if (eret_m) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    // Timer, present only when enabled
    if (TIMER_EN) begin : g_timer
        cp0_timer u_timer (
            .clk        (clk),
            .reset      (reset),
            .wr_count   (mtc0_c && (wr_addr == REG_COUNT)),
            .wr_compare (mtc0_c && (wr_addr == REG_COMPARE)),
            .wr_data    (wr_data),
            .ti         (ti),
            .count      (count),
            .compare    (compare)
        );
    end else begin : g_no_timer
        assign ti      = 1'b0;
        assign count   = '0;
        assign compare = '0;
    end

endmodule

// File: doc/cp0_ext.md
# cp0_ext

Parametrised system-control coprocessor for the five-stage MIPS pipeline, successor to the existing CP0. It sits beside the M stage and decides exception and interrupt entry. It holds SR, Cause, EPC, PRID, BadVAddr and a Count/Compare timer that raises an internal interrupt. Compared with the previous generation it adds:
- a configurable hardware-interrupt width,
- software interrupt bits,
- BadVAddr capture,
- interrupt-over-exception priority,
- defined arbitration when MTC0, ERET and exception entry collide.

## Interface
Parameters:
- N_HWINT, 6, number of external interrupt lines (1..6), mapped to Cause.IP[2+i]
- PRID_VAL, 32'h18373580, constant read from PRID
- TIMER_EN, 1, enables Count/Compare; when 0, Count reads 0 and TI never sets

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- rd_addr  in  5  MFC0 register number
- rd_data  out  32  MFC0 read data
- wr_en  in  1  MTC0 write enable (M stage)
- wr_addr  in  5  MTC0 register number
- wr_data  in  32  MTC0 data
- pc_m  in  32  PC of the M-stage instruction
- bd_m  in  1  M-stage instruction is in a delay slot
- exc_code_m  in  5  exception code of the M-stage instruction; 0 means none
- bad_vaddr_m  in  32  faulting address, valid with code 4/5
- eret_m  in  1  ERET in M stage
- hw_int  in  N_HWINT  external interrupt levels
- int_req  out  1  take exception/interrupt now (flushes pipeline, redirects to handler)
- epc  out  32  current EPC, used by ERET
- timer_irq  out  1  Cause.TI

## Operation
Register map (number: fields):
- 8 BadVAddr: read-only
- 9 Count: read/write
- 11 Compare: read/write
- 12 SR: IM[15:8], EXL[1], IE[0] writable; other bits 0
- 13 Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[1:0] writable
- 14 EPC: writable; bits [1:0] forced to 0
- 15 PRID: PRID_VAL, writes ignored
- Unmapped read returns 0; unmapped write is ignored.

Interrupt and exception logic:
- IP[2+i] is registered from hw_int[i] every cycle. IP[7] is ORed with TI. Unused IP bits read 0.
- irq_pend = |(IP & IM) & IE & !EXL
- exc = exc_code_m != 0 (exceptions ignore EXL and IE)
- int_req = irq_pend | exc. The interrupt has priority: ExcCode is recorded as 0.

Entry, on the edge where int_req = 1:
- EXL <= 1
- BD <= bd_m
- ExcCode <= irq_pend ? 0 : exc_code_m
- EPC <= {pc_m[31:2],2'b00} − (bd_m ? 4 : 0)
- BadVAddr <= bad_vaddr_m if the recorded code is 4 or 5

Exit and writes:
- eret_m without int_req: EXL <= 0.
- Same-cycle collisions: int_req beats eret_m; int_req beats MTC0, and the write is dropped. Otherwise MTC0 applies on the edge.

Timer:
- Count increments every cycle and wraps from 32'hFFFFFFFF to 0. An MTC0 to Count loads wr_data instead of incrementing.
- TI sets on the edge where the next Count value equals Compare.
- An MTC0 to Compare loads Compare and clears TI on the same edge; set wins over clear is not possible, because the clear takes priority.

## Timing
- rd_data, int_req and epc are combinational from current state and M-stage inputs.
- All state updates occur on the next rising edge.
- No MTC0→MFC0 bypass: a read in the write cycle returns the old value.
- Reset (low, any time, including mid-entry): registers go to 0 and PRID = PRID_VAL. While low:
  - int_req = 0 when exc_code_m = 0
  - rd_data follows rd_addr
  - epc = 0
  - timer_irq = 0
- Count resumes from 0 on the first edge after release.
- hw_int to int_req latency: 1 edge (IP registration), provided IM, IE = 1 and EXL = 0.
- Timer: int_req is asserted in the cycle after Count reaches Compare.

## Structure
- cp0_pkg holds the shared constants:
  - register numbers 8, 9, 11–15
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12
  - SR/Cause field bit positions
- Sub-module cp0_timer contains Count, Compare and TI. Its interface is clk, reset, write strobes, write data and TI/count/compare outputs. It is instantiated only when TIMER_EN = 1; otherwise its outputs are tied to 0.

## Test plan
- Reset release; SR=32'h0000_0401; hw_int[0] pulsed → int_req high 1 cycle later; after edge: ExcCode=0, EXL=1, EPC=pc_m.
- exc_code_m=12, bd_m=1, pc_m=32'h3004 → EPC=32'h3000, Cause=32'h8000_0030, EXL=1; MTC0 in the same cycle is dropped.
- exc_code_m=4, bad_vaddr_m=32'h1001 → BadVAddr=32'h1001; eret_m next cycle → EXL=0, epc unchanged.
- Compare=10, Count=5, IM[7]=1, IE=1 → TI and int_req after 5 edges; MTC0 Compare clears TI. Count=32'hFFFFFFFF → wraps to 0.
- Interrupt pending with exc_code_m=10 → ExcCode=0. EXL=1 with hw_int high → int_req=0. Reset pulled low mid-sequence → all fields 0, PRID=32'h18373580.
